// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_ctrl
//  Purpose  : Hazard and forwarding controller for the ID/EX pipeline
//             register. It tracks the destination registers in flight in
//             EX, MEM and WB with a shadow scoreboard. From that state and
//             the ID-stage sources it produces:
//               - operand forward enables and data (priority EX > MEM > WB)
//               - the single-cycle load-use stall
//               - redirect flushes for taken branches and jumps resolved in EX
//  Ports    : clk, rst_n (async, active-low)
//             ID inputs   : id_valid_i, rs1/rs2_id_i, rs1/rs2_used_i,
//                           wr_id_i, rf_we_id_i, wd_sel_id_i
//             Fwd data in : ex_fwd_data_i, mem_fwd_data_i, wb_fwd_data_i
//             Redirect    : redirect_ex_i
//             Control out : stall_pc_o, stall_if_id_o, flush_if_id_o,
//                           flush_id_ex_o
//             Forward out : fwd_rD1e_o, fwd_rD2e_o, fwd_rD1_o, fwd_rD2_o
//             Perf out    : perf_stall_cnt_o, perf_flush_cnt_o
//  Options  : HAZARD_PERF_CNT_EN - when defined, builds the load-use stall
//             and redirect counters. Otherwise both perf outputs are 0.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl #(
    parameter int         XLEN        = 32,
    parameter int         NREG_BITS   = 5,
    parameter logic [1:0] WD_SEL_DRAM = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid_i,
    input  logic [NREG_BITS-1:0] rs1_id_i,
    input  logic [NREG_BITS-1:0] rs2_id_i,
    input  logic                 rs1_used_i,
    input  logic                 rs2_used_i,
    input  logic [NREG_BITS-1:0] wr_id_i,
    input  logic                 rf_we_id_i,
    input  logic [1:0]           wd_sel_id_i,
    input  logic [XLEN-1:0]      ex_fwd_data_i,
    input  logic [XLEN-1:0]      mem_fwd_data_i,
    input  logic [XLEN-1:0]      wb_fwd_data_i,
    input  logic                 redirect_ex_i,
    output logic                 stall_pc_o,
    output logic                 stall_if_id_o,
    output logic                 flush_if_id_o,
    output logic                 flush_id_ex_o,
    output logic                 fwd_rD1e_o,
    output logic                 fwd_rD2e_o,
    output logic [XLEN-1:0]      fwd_rD1_o,
    output logic [XLEN-1:0]      fwd_rD2_o,
    output logic [31:0]          perf_stall_cnt_o,
    output logic [31:0]          perf_flush_cnt_o
);

    typedef struct packed {
        logic                 v;
        logic [NREG_BITS-1:0] rd;
        logic                 we;
        logic                 ld;
    } slot_t;

    slot_t r_ex, r_mem, r_wb;
    slot_t w_ex_next;

    // A slot supplies an operand only for a real, register-writing
    // instruction whose destination is not x0 and matches a source that
    // the valid ID instruction actually reads.
    function automatic logic f_hit(input slot_t s,
                                   input logic [NREG_BITS-1:0] rs,
                                   input logic used,
                                   input logic idv);
        return s.v && s.we && (s.rd != '0) && (s.rd == rs) && used && idv;
    endfunction

    logic [1:0]                 w_used;
    logic [1:0][NREG_BITS-1:0]  w_rs;
    logic [1:0]                 w_hit_ex;
    logic [1:0]                 w_fwd_en;
    logic [1:0][XLEN-1:0]       w_fwd_data;
    logic                       w_load_use;
    logic                       w_redirect;

    assign w_rs[0]   = rs1_id_i;
    assign w_rs[1]   = rs2_id_i;
    assign w_used[0] = rs1_used_i;
    assign w_used[1] = rs2_used_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            logic            hit_ex, hit_mem, hit_wb;
            logic            en;
            logic [XLEN-1:0] data;

            assign hit_ex  = f_hit(r_ex,  w_rs[gi], w_used[gi], id_valid_i);
            assign hit_mem = f_hit(r_mem, w_rs[gi], w_used[gi], id_valid_i);
            assign hit_wb  = f_hit(r_wb,  w_rs[gi], w_used[gi], id_valid_i);

            // A load hit in EX masks the older stages: its data does not
            // exist yet, so the operand stays unforwarded while stalling.
            always_comb begin
                en   = 1'b0;
                data = '0;
                if (hit_ex) begin
                    if (!r_ex.ld) begin
                        en   = 1'b1;
                        data = ex_fwd_data_i;
                    end
                end else if (hit_mem) begin
                    en   = 1'b1;
                    data = mem_fwd_data_i;
                end else if (hit_wb) begin
                    en   = 1'b1;
                    data = wb_fwd_data_i;
                end
            end

            assign w_hit_ex[gi]   = hit_ex;
            assign w_fwd_en[gi]   = en;
            assign w_fwd_data[gi] = data;
        end
    endgenerate

    assign w_load_use = r_ex.ld && (|w_hit_ex);
    // Gated with reset so an asserted redirect cannot leak flushes while
    // the controller is held in reset.
    assign w_redirect = rst_n && redirect_ex_i;

    // Redirect beats load-use: the ID instruction is wrong-path, so the PC
    // must load the target rather than hold.
    assign stall_pc_o    = w_load_use && !w_redirect;
    assign stall_if_id_o = w_load_use && !w_redirect;
    assign flush_if_id_o = w_redirect;
    assign flush_id_ex_o = w_load_use || w_redirect;

    assign fwd_rD1e_o = w_fwd_en[0];
    assign fwd_rD2e_o = w_fwd_en[1];
    assign fwd_rD1_o  = w_fwd_data[0];
    assign fwd_rD2_o  = w_fwd_data[1];

    always_comb begin
        w_ex_next = '0;
        if (!flush_id_ex_o) begin
            w_ex_next.v  = id_valid_i;
            w_ex_next.rd = wr_id_i;
            w_ex_next.we = rf_we_id_i;
            w_ex_next.ld = (wd_sel_id_i == WD_SEL_DRAM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_ex  <= w_ex_next;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_load_use && !w_redirect) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (w_redirect) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = r_perf_stall_cnt;
    assign perf_flush_cnt_o = r_perf_flush_cnt;
`else
    assign perf_stall_cnt_o = 32'd0;
    assign perf_flush_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_fwd_ctrl
//  Purpose  : Directed self-checking bench for hazard_fwd_ctrl. Covers
//             reset, forwarding priority, load-use stall, x0 guard,
//             redirect vs load-use and async reset during a stall.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid_i;
    logic [4:0]  rs1_id_i, rs2_id_i, wr_id_i;
    logic        rs1_used_i, rs2_used_i, rf_we_id_i;
    logic [1:0]  wd_sel_id_i;
    logic [31:0] ex_fwd_data_i, mem_fwd_data_i, wb_fwd_data_i;
    logic        redirect_ex_i;
    logic        stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o;
    logic        fwd_rD1e_o, fwd_rD2e_o;
    logic [31:0] fwd_rD1_o, fwd_rD2_o;
    logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;

    int tests = 0;
    int fails = 0;

    hazard_fwd_ctrl #(.XLEN(32), .NREG_BITS(5), .WD_SEL_DRAM(2'b01)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid_i       (id_valid_i),
        .rs1_id_i         (rs1_id_i),
        .rs2_id_i         (rs2_id_i),
        .rs1_used_i       (rs1_used_i),
        .rs2_used_i       (rs2_used_i),
        .wr_id_i          (wr_id_i),
        .rf_we_id_i       (rf_we_id_i),
        .wd_sel_id_i      (wd_sel_id_i),
        .ex_fwd_data_i    (ex_fwd_data_i),
        .mem_fwd_data_i   (mem_fwd_data_i),
        .wb_fwd_data_i    (wb_fwd_data_i),
        .redirect_ex_i    (redirect_ex_i),
        .stall_pc_o       (stall_pc_o),
        .stall_if_id_o    (stall_if_id_o),
        .flush_if_id_o    (flush_if_id_o),
        .flush_id_ex_o    (flush_id_ex_o),
        .fwd_rD1e_o       (fwd_rD1e_o),
        .fwd_rD2e_o       (fwd_rD2e_o),
        .fwd_rD1_o        (fwd_rD1_o),
        .fwd_rD2_o        (fwd_rD2_o),
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Present one instruction in ID: {valid, rd, we, wd_sel, rs1, used1, rs2, used2}
    task automatic drive_id(input logic v, input logic [4:0] rd, input logic we,
                            input logic [1:0] ws, input logic [4:0] r1, input logic u1,
                            input logic [4:0] r2, input logic u2);
        id_valid_i  = v;   wr_id_i    = rd; rf_we_id_i = we; wd_sel_id_i = ws;
        rs1_id_i    = r1;  rs1_used_i = u1;
        rs2_id_i    = r2;  rs2_used_i = u2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive_id(1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (3) step();
    endtask

    task automatic test_reset();
        redirect_ex_i = 1'b1;
        @(negedge clk);
        tests++; if (flush_if_id_o !== 1'b0) begin fails++; $display("FAIL reset_flush_if_id got=%b exp=0", flush_if_id_o); end
        tests++; if (flush_id_ex_o !== 1'b0) begin fails++; $display("FAIL reset_flush_id_ex got=%b exp=0", flush_id_ex_o); end
        tests++; if ({stall_pc_o, stall_if_id_o, fwd_rD1e_o, fwd_rD2e_o} !== 4'b0000) begin
            fails++; $display("FAIL reset_stall_fwd got=%b exp=0000", {stall_pc_o, stall_if_id_o, fwd_rD1e_o, fwd_rD2e_o}); end
        tests++; if ({fwd_rD1_o, fwd_rD2_o, perf_stall_cnt_o, perf_flush_cnt_o} !== 128'd0) begin
            fails++; $display("FAIL reset_data got=%h exp=0", {fwd_rD1_o, fwd_rD2_o, perf_stall_cnt_o, perf_flush_cnt_o}); end
        redirect_ex_i = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ex_fwd();
        drive_id(1'b1, 5'd5, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0); // addi x5
        step();
        drive_id(1'b1, 5'd0, 1'b0, 2'b00, 5'd5, 1'b1, 5'd0, 1'b0);
        ex_fwd_data_i = 32'h11; mem_fwd_data_i = 32'hAA; wb_fwd_data_i = 32'hBB;
        @(negedge clk);
        tests++; if (fwd_rD1e_o !== 1'b1 || fwd_rD1_o !== 32'h11) begin
            fails++; $display("FAIL ex_fwd_rD1 got=%b/%h exp=1/00000011", fwd_rD1e_o, fwd_rD1_o); end
        tests++; if (stall_pc_o !== 1'b0 || fwd_rD2e_o !== 1'b0) begin
            fails++; $display("FAIL ex_fwd_nostall got=%b%b exp=00", stall_pc_o, fwd_rD2e_o); end
        drain();
    endtask

    task automatic test_ex_over_mem();
        drive_id(1'b1, 5'd5, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd5, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 5'd5, 1'b1);
        ex_fwd_data_i = 32'h33; mem_fwd_data_i = 32'h22;
        @(negedge clk);
        tests++; if (fwd_rD2e_o !== 1'b1 || fwd_rD2_o !== 32'h33) begin
            fails++; $display("FAIL ex_over_mem got=%b/%h exp=1/00000033", fwd_rD2e_o, fwd_rD2_o); end
        tests++; if (fwd_rD1e_o !== 1'b0) begin
            fails++; $display("FAIL ex_over_mem_rs1_unused got=%b exp=0", fwd_rD1e_o); end
        drain();
    endtask

    task automatic test_mem_wb();
        drive_id(1'b1, 5'd9, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd9, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        // EX=bubble, MEM=x9 (second), WB=x9 (first)
        drive_id(1'b1, 5'd0, 1'b0, 2'b00, 5'd9, 1'b1, 5'd9, 1'b1);
        ex_fwd_data_i = 32'h66; mem_fwd_data_i = 32'h44; wb_fwd_data_i = 32'h55;
        @(negedge clk);
        tests++; if ({fwd_rD1e_o, fwd_rD2e_o} !== 2'b11 || fwd_rD1_o !== 32'h44 || fwd_rD2_o !== 32'h44) begin
            fails++; $display("FAIL mem_over_wb got=%b%b/%h/%h exp=11/00000044", fwd_rD1e_o, fwd_rD2e_o, fwd_rD1_o, fwd_rD2_o); end
        step();
        @(negedge clk);
        tests++; if (fwd_rD1e_o !== 1'b1 || fwd_rD1_o !== 32'h55) begin
            fails++; $display("FAIL wb_fwd got=%b/%h exp=1/00000055", fwd_rD1e_o, fwd_rD1_o); end
        step();
        @(negedge clk);
        tests++; if ({fwd_rD1e_o, fwd_rD2e_o} !== 2'b00 || fwd_rD1_o !== 32'h0 || fwd_rD2_o !== 32'h0) begin
            fails++; $display("FAIL no_fwd got=%b%b/%h/%h exp=00/0", fwd_rD1e_o, fwd_rD2e_o, fwd_rD1_o, fwd_rD2_o); end
        drain();
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 5'd7, 1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0); // lw x7
        step();
        drive_id(1'b1, 5'd8, 1'b1, 2'b00, 5'd7, 1'b1, 5'd0, 1'b0);
        ex_fwd_data_i = 32'hBAD; mem_fwd_data_i = 32'hDEAD;
        @(negedge clk);
        tests++; if ({stall_pc_o, stall_if_id_o, flush_id_ex_o, flush_if_id_o, fwd_rD1e_o} !== 5'b11100) begin
            fails++; $display("FAIL load_use_c0 got=%b exp=11100", {stall_pc_o, stall_if_id_o, flush_id_ex_o, flush_if_id_o, fwd_rD1e_o}); end
        step();
        @(negedge clk);
        tests++; if (fwd_rD1e_o !== 1'b1 || fwd_rD1_o !== 32'hDEAD) begin
            fails++; $display("FAIL load_use_c1_fwd got=%b/%h exp=1/0000dead", fwd_rD1e_o, fwd_rD1_o); end
        tests++; if ({stall_pc_o, stall_if_id_o, flush_id_ex_o} !== 3'b000) begin
            fails++; $display("FAIL load_use_c1_nostall got=%b exp=000", {stall_pc_o, stall_if_id_o, flush_id_ex_o}); end
        tests++; if (perf_stall_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin
            fails++; $display("FAIL perf_stall_after_lu got=%0d exp=%0d", perf_stall_cnt_o, PERF ? 1 : 0); end
        drain();
    endtask

    task automatic test_x0();
        drive_id(1'b1, 5'd0, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd0, 1'b0, 2'b00, 5'd0, 1'b1, 5'd0, 1'b1);
        ex_fwd_data_i = 32'h77;
        @(negedge clk);
        tests++; if ({fwd_rD1e_o, fwd_rD2e_o} !== 2'b00) begin
            fails++; $display("FAIL x0_guard got=%b%b exp=00", fwd_rD1e_o, fwd_rD2e_o); end
        drain();
    endtask

    task automatic test_redirect_load_use();
        drive_id(1'b1, 5'd3, 1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0); // lw x3
        step();
        drive_id(1'b1, 5'd4, 1'b1, 2'b00, 5'd3, 1'b1, 5'd0, 1'b0);
        redirect_ex_i = 1'b1;
        @(negedge clk);
        tests++; if ({flush_if_id_o, flush_id_ex_o, stall_pc_o, stall_if_id_o} !== 4'b1100) begin
            fails++; $display("FAIL redirect_lu got=%b exp=1100", {flush_if_id_o, flush_id_ex_o, stall_pc_o, stall_if_id_o}); end
        tests++; if (perf_flush_cnt_o !== 32'd0) begin
            fails++; $display("FAIL perf_flush_before got=%0d exp=0", perf_flush_cnt_o); end
        step();
        redirect_ex_i = 1'b0;
        @(negedge clk);
        tests++; if (perf_flush_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin
            fails++; $display("FAIL perf_flush_after got=%0d exp=%0d", perf_flush_cnt_o, PERF ? 1 : 0); end
        tests++; if (perf_stall_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin
            fails++; $display("FAIL perf_stall_unchanged got=%0d exp=%0d", perf_stall_cnt_o, PERF ? 1 : 0); end
        drain();
        // plain redirect with nothing in flight
        drive_id(1'b1, 5'd1, 1'b1, 2'b00, 5'd2, 1'b1, 5'd0, 1'b0);
        redirect_ex_i = 1'b1;
        @(negedge clk);
        tests++; if ({flush_if_id_o, flush_id_ex_o, stall_pc_o} !== 3'b110) begin
            fails++; $display("FAIL redirect_plain got=%b exp=110", {flush_if_id_o, flush_id_ex_o, stall_pc_o}); end
        step();
        redirect_ex_i = 1'b0;
        // the flushed instruction must not appear as a forwarding source
        drive_id(1'b1, 5'd0, 1'b0, 2'b00, 5'd1, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        tests++; if (fwd_rD1e_o !== 1'b0) begin
            fails++; $display("FAIL redirect_bubble got=%b exp=0", fwd_rD1e_o); end
        drain();
    endtask

    task automatic test_async_reset();
        drive_id(1'b1, 5'd7, 1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd8, 1'b1, 2'b00, 5'd7, 1'b1, 5'd0, 1'b0);
        #1;
        tests++; if (stall_pc_o !== 1'b1) begin
            fails++; $display("FAIL arst_pre_stall got=%b exp=1", stall_pc_o); end
        #1 rst_n = 1'b0;
        #1;
        tests++; if ({stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o, fwd_rD1e_o, fwd_rD2e_o} !== 6'b0) begin
            fails++; $display("FAIL arst_ctrl got=%b exp=000000", {stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o, fwd_rD1e_o, fwd_rD2e_o}); end
        tests++; if ({fwd_rD1_o, fwd_rD2_o, perf_stall_cnt_o, perf_flush_cnt_o} !== 128'd0) begin
            fails++; $display("FAIL arst_data got=%h exp=0", {fwd_rD1_o, fwd_rD2_o, perf_stall_cnt_o, perf_flush_cnt_o}); end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        tests++; if ({fwd_rD1e_o, stall_pc_o, flush_id_ex_o} !== 3'b000) begin
            fails++; $display("FAIL arst_post got=%b exp=000", {fwd_rD1e_o, stall_pc_o, flush_id_ex_o}); end
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_ex_i = 1'b0;
        ex_fwd_data_i = '0; mem_fwd_data_i = '0; wb_fwd_data_i = '0;
        drive_id(1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
        test_reset();
        test_ex_fwd();
        test_ex_over_mem();
        test_mem_wb();
        test_load_use();
        test_x0();
        test_redirect_load_use();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Hazard and forwarding controller driving the ID/EX pipeline register's control-side inputs: flush, forward enables and forward data for rD1/rD2. It keeps a shadow scoreboard of destination registers in flight in EX, MEM and WB. From that scoreboard and the ID-stage source registers it produces:
- forward selects and data;
- load-use stall;
- redirect flushes for taken branches and jumps resolved in EX.

Parameters:
- XLEN, 32, datapath width
- NREG_BITS, 5, register index width
- WD_SEL_DRAM, 2'b01, wd_sel encoding meaning "write-back from data memory (load)"

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  valid instruction in ID
- rs1_id_i  in  5  ID source reg 1
- rs2_id_i  in  5  ID source reg 2
- rs1_used_i  in  1  instruction reads rs1
- rs2_used_i  in  1  instruction reads rs2
- wr_id_i  in  5  ID destination reg
- rf_we_id_i  in  1  ID writes RF
- wd_sel_id_i  in  2  ID write-back source
- ex_fwd_data_i  in  XLEN  EX-stage result, non-load
- mem_fwd_data_i  in  XLEN  MEM-stage final write data, load data included
- wb_fwd_data_i  in  XLEN  WB-stage write data
- redirect_ex_i  in  1  taken branch/jump resolved in EX
- stall_pc_o  out  1  hold PC
- stall_if_id_o  out  1  hold IF/ID
- flush_if_id_o  out  1  bubble IF/ID
- flush_id_ex_o  out  1  bubble ID/EX (drives PR_ID_EX flush)
- fwd_rD1e_o  out  1  forward enable rD1
- fwd_rD2e_o  out  1  forward enable rD2
- fwd_rD1_o  out  XLEN  forward data rD1
- fwd_rD2_o  out  XLEN  forward data rD2
- perf_stall_cnt_o  out  32  load-use stall cycles (optional feature)
- perf_flush_cnt_o  out  32  redirect events (optional feature)

Behaviour:
- Scoreboard: three slots EX, MEM, WB, each holding {v, rd, we, is_load}; is_load = (wd_sel == WD_SEL_DRAM).
- Shift on every clk edge:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (v=0) if flush_id_ex_o, else {id_valid_i, wr_id_i, rf_we_id_i, is_load(wd_sel_id_i)}.
- Reset: all slots v=0; every output 0; perf counters 0. Reset mid-operation clears the scoreboard immediately (async).
- A slot hits rsN when: v && we && rd != 0 && rd == rsN && rsN_used && id_valid_i.
- Forward priority (combinational): EX > MEM > WB.
  - EX hit with is_load=0 -> ex_fwd_data_i.
  - Else MEM hit -> mem_fwd_data_i.
  - Else WB hit -> wb_fwd_data_i.
  - Else fwd_rDNe_o=0 and fwd_rDN_o=0.
  - x0 is never forwarded.
- Load-use: EX hit with is_load=1 on either used source -> load_use=1.
  - stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1.
  - Forward enable for that operand is 0 during the stall cycle.
  - Next cycle the load sits in MEM and is forwarded from mem_fwd_data_i. Stall lasts exactly 1 cycle.
- Redirect: redirect_ex_i=1 -> flush_if_id_o=1 and flush_id_ex_o=1 in the same cycle.
  - stall_pc_o=0 and stall_if_id_o=0, so the PC loads the target.
- Simultaneous redirect and load-use: redirect wins. No stall; both flushes asserted. The ID instruction is wrong-path.
- All control outputs are combinational from scoreboard state plus current inputs. No extra latency.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - perf_stall_cnt_o increments each cycle load_use is active and redirect is not.
  - perf_flush_cnt_o increments each cycle redirect_ex_i=1.
  - Both are 32-bit, wrap at 0xFFFFFFFF -> 0, and reset to 0.
- Undefined: both outputs tied to 0; no counter flops.

Test Plan:
- ALU hazard, EX priority: addi x5 (rd=5, we=1, wd_sel=00) in EX; ID rs1=5, rs1_used=1; ex_fwd_data_i=0x11 -> fwd_rD1e_o=1, fwd_rD1_o=0x11, no stall.
- EX over MEM priority: x5 in MEM with mem_fwd_data_i=0x22 and x5 in EX with ex_fwd_data_i=0x33; ID rs2=5 -> fwd_rD2_o=0x33.
- Load-use: lw x7 in EX (wd_sel=01); ID rs1=7.
  - Cycle 0: stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1, fwd_rD1e_o=0.
  - Cycle 1: load in MEM with mem_fwd_data_i=0xDEAD -> fwd_rD1e_o=1, fwd_rD1_o=0xDEAD, no stall.
- x0 guard: EX slot rd=0, we=1; ID rs1=0 -> fwd_rD1e_o=0.
- Redirect and load-use in the same cycle -> flush_if_id_o=1, flush_id_ex_o=1, stall_pc_o=0. With HAZARD_PERF_CNT_EN: perf_flush_cnt_o 0->1 and perf_stall_cnt_o stays 0.
- Async reset mid-stall: assert rst_n=0 during a load-use stall -> all outputs 0 immediately. After release with no new instructions, no forward is asserted, since the scoreboard was cleared.
